// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int HOLD_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage : mux_arb_pkg

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after start_i,
// wrapping; the excluded slot is the one just before start_i (the current owner).
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  input  logic               excl_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    // Walk from the farthest slot back to start_i so the nearest hit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[start_i + IDX_W'(k)] && !(excl_i && (k == NUM_REQ - 1))) begin
        found_o = 1'b1;
        idx_o   = start_i + IDX_W'(k);
      end
    end
  end

endmodule : rr_pick

// File: rtl/mux_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select lines from a registered grant,
// with a bounded hold time so that a waiting requester is never starved.
//
// state | meaning
// IDLE  | no owner; address holds the last owner's index
// BUSY  | owner_q holds the mux, cnt_q counts consecutive held cycles
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               address0,
  output logic               address1,
  output logic               valid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;

  logic [IDX_W-1:0]   pick_start;
  logic               pick_excl;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               take;

  assign pick_start = (state_q == BUSY) ? owner_q + IDX_W'(1) : ptr_q + IDX_W'(1);
  assign pick_excl  = (state_q == BUSY);

  rr_pick u_pick (
    .req_i   (req),
    .start_i (pick_start),
    .excl_i  (pick_excl),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    valid_d = valid_q;
    take    = 1'b0;

    case (state_q)
      IDLE: begin
        take = pick_found;
      end
      BUSY: begin
        if (!req[owner_q]) begin
          // Release wins over a coincident preempt.
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end else if ((cnt_q == HOLD_LAST) && pick_found) begin
          take = 1'b1;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      state_d = BUSY;
      owner_d = pick_idx;
      ptr_d   = pick_idx;
      cnt_d   = '0;
      grant_d = NUM_REQ'(1) << pick_idx;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign grant    = grant_q;
  assign valid    = valid_q;
  assign address0 = owner_q[0];
  assign address1 = owner_q[1];

endmodule : mux_arbiter
